// File: rtl/interrupt_ack_sequencer.sv
// Purpose: 8259-style CPU-side acknowledge sequencer: INT, two-pulse INTA, ISR, EOI and priority rotation.
// Latency: int_out one cycle after a request; vector byte one cycle after the second INTA pulse.
// Backpressure: none; the CPU paces the sequence through inta_pulse, and withdrawn requests drop INT.
module interrupt_ack_sequencer #(
    parameter int NUM_LEVELS     = 8,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_LEVELS-1:0] interrupt,
    input  logic                  init_strobe,
    input  logic [4:0]            vector_base,
    input  logic                  auto_eoi,
    input  logic                  rotate_on_aeoi,
    input  logic                  inta_pulse,
    input  logic                  eoi_strobe,
    input  logic                  eoi_specific,
    input  logic                  eoi_rotate,
    input  logic                  set_priority_strobe,
    input  logic [2:0]            eoi_level,
    output logic                  int_out,
    output logic [NUM_LEVELS-1:0] in_service_register,
    output logic [NUM_LEVELS-1:0] highest_level_in_service,
    output logic [2:0]            priority_rotate,
    output logic [NUM_LEVELS-1:0] clear_request,
    output logic [7:0]            data_out,
    output logic                  data_valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK1 = 2'd1,
        WAIT_ACK2 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              level_q, level_d;
    logic                    spurious_q, spurious_d;
    logic                    int_q, int_d;
    logic [NUM_LEVELS-1:0]   isr_q, isr_d;
    logic [2:0]              rotate_q, rotate_d;
    logic [NUM_LEVELS-1:0]   clear_q, clear_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;

    logic [2:0]              scan_idx;
    logic                    hl_found;
    logic [2:0]              hl_lvl;
    logic [NUM_LEVELS-1:0]   hl_vec;
    logic [2:0]              req_lvl;
    logic [NUM_LEVELS-1:0]   clr_mask;
    logic [NUM_LEVELS-1:0]   set_mask;

    // Scan starts just above the lowest-priority level and wraps around.
    always_comb begin
        scan_idx = '0;
        hl_found = 1'b0;
        hl_lvl   = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            scan_idx = rotate_q + 3'd1 + 3'(i);
            if (!hl_found && isr_q[scan_idx]) begin
                hl_found = 1'b1;
                hl_lvl   = scan_idx;
            end
        end
        hl_vec = hl_found ? (NUM_LEVELS'(1) << hl_lvl) : '0;
    end

    always_comb begin
        req_lvl = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (interrupt[i]) begin
                req_lvl = 3'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        spurious_d = spurious_q;
        int_d      = int_q;
        rotate_d   = rotate_q;
        clear_d    = '0;
        data_d     = data_q;
        valid_d    = 1'b0;
        clr_mask   = '0;
        set_mask   = '0;

        case (state_q)
            IDLE: begin
                if (interrupt != '0) begin
                    int_d   = 1'b1;
                    state_d = WAIT_ACK1;
                end
            end
            WAIT_ACK1: begin
                if (inta_pulse) begin
                    state_d = WAIT_ACK2;
                    if (interrupt != '0) begin
                        level_d    = req_lvl;
                        spurious_d = 1'b0;
                        set_mask   = NUM_LEVELS'(1) << req_lvl;
                        clear_d    = NUM_LEVELS'(1) << req_lvl;
                    end else begin
                        level_d    = 3'(SPURIOUS_LEVEL);
                        spurious_d = 1'b1;
                    end
                end else if (interrupt == '0) begin
                    int_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_ACK2: begin
                if (inta_pulse) begin
                    data_d  = {vector_base, level_q};
                    valid_d = 1'b1;
                    int_d   = 1'b0;
                    state_d = IDLE;
                    if (auto_eoi && !spurious_q) begin
                        clr_mask = NUM_LEVELS'(1) << level_q;
                        if (rotate_on_aeoi) begin
                            rotate_d = level_q;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase

        if (eoi_strobe) begin
            if (eoi_specific) begin
                clr_mask = clr_mask | (NUM_LEVELS'(1) << eoi_level);
                if (eoi_rotate) begin
                    rotate_d = eoi_level;
                end
            end else if (hl_found) begin
                clr_mask = clr_mask | hl_vec;
                if (eoi_rotate) begin
                    rotate_d = hl_lvl;
                end
            end
        end

        if (set_priority_strobe) begin
            rotate_d = eoi_level;
        end

        // Clears act on the pre-edge ISR; a same-edge set of the same bit wins.
        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clock) begin
        if (!reset_n || init_strobe) begin
            state_q    <= IDLE;
            level_q    <= '0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            isr_q      <= '0;
            rotate_q   <= 3'b111;
            clear_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            spurious_q <= spurious_d;
            int_q      <= int_d;
            isr_q      <= isr_d;
            rotate_q   <= rotate_d;
            clear_q    <= clear_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign int_out                  = int_q;
    assign in_service_register      = isr_q;
    assign highest_level_in_service = hl_vec;
    assign priority_rotate          = rotate_q;
    assign clear_request            = clear_q;
    assign data_out                 = data_q;
    assign data_valid               = valid_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer; vector bytes are scoreboarded
// when the second INTA is driven and matched when data_valid is seen.
module tb_interrupt_ack_sequencer;

    logic       clock;
    logic       reset_n;
    logic [7:0] interrupt;
    logic       init_strobe;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       rotate_on_aeoi;
    logic       inta_pulse;
    logic       eoi_strobe;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic       set_priority_strobe;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [7:0] clear_request;
    logic [7:0] data_out;
    logic       data_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q[$];

    interrupt_ack_sequencer dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .interrupt                (interrupt),
        .init_strobe              (init_strobe),
        .vector_base              (vector_base),
        .auto_eoi                 (auto_eoi),
        .rotate_on_aeoi           (rotate_on_aeoi),
        .inta_pulse               (inta_pulse),
        .eoi_strobe               (eoi_strobe),
        .eoi_specific             (eoi_specific),
        .eoi_rotate               (eoi_rotate),
        .set_priority_strobe      (set_priority_strobe),
        .eoi_level                (eoi_level),
        .int_out                  (int_out),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .clear_request            (clear_request),
        .data_out                 (data_out),
        .data_valid               (data_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb_q.pop_front();
                chk("data_out", {24'd0, data_out}, {24'd0, exp_b});
            end
        end
    end

    task automatic ack(input logic [2:0] lvl);
        interrupt = 8'd1 << lvl;
        tick();
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        interrupt  = 8'h00;
        sb_q.push_back({vector_base, lvl});
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        tick();
    endtask

    task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
        eoi_strobe   = 1'b1;
        eoi_specific = spec;
        eoi_rotate   = rot;
        eoi_level    = lvl;
        tick();
        eoi_strobe   = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
    endtask

    task automatic set_prio(input logic [2:0] lvl);
        set_priority_strobe = 1'b1;
        eoi_level           = lvl;
        tick();
        set_priority_strobe = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; interrupt = 8'h00; init_strobe = 1'b0; vector_base = 5'b01000;
        auto_eoi = 1'b0; rotate_on_aeoi = 1'b0; inta_pulse = 1'b0; eoi_strobe = 1'b0;
        eoi_specific = 1'b0; eoi_rotate = 1'b0; set_priority_strobe = 1'b0; eoi_level = 3'd0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_int", int_out, 0);
        chk("rst_isr", in_service_register, 0);
        chk("rst_rot", priority_rotate, 7);
        chk("rst_valid", data_valid, 0);
        chk("rst_clr", clear_request, 0);
        chk("rst_hl", highest_level_in_service, 0);

        // Basic two-pulse acknowledge of level 2
        interrupt = 8'h04;
        tick();
        chk("t1_int", int_out, 1);
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        interrupt  = 8'h00;
        chk("t1_clr", clear_request, 8'h04);
        chk("t1_isr", in_service_register, 8'h04);
        chk("t1_hl", highest_level_in_service, 8'h04);
        chk("t1_int_held", int_out, 1);
        tick();
        chk("t1_clr_pulse", clear_request, 0);
        sb_q.push_back(8'h42);
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        chk("t1_valid", data_valid, 1);
        chk("t1_int_fall", int_out, 0);
        tick();
        chk("t1_valid_pulse", data_valid, 0);
        chk("t1_isr_kept", in_service_register, 8'h04);
        eoi(1'b1, 1'b0, 3'd2);
        chk("t1_eoi", in_service_register, 0);

        // Withdrawn request
        interrupt = 8'h10;
        tick();
        chk("t2_int", int_out, 1);
        interrupt = 8'h00;
        tick();
        chk("t2_withdraw", int_out, 0);
        tick();
        chk("t2_idle", int_out, 0);

        // Spurious: request gone at first INTA
        interrupt = 8'h10;
        tick();
        interrupt  = 8'h00;
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        chk("t2_sp_clr", clear_request, 0);
        chk("t2_sp_isr", in_service_register, 0);
        chk("t2_sp_int", int_out, 1);
        sb_q.push_back(8'h47);
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        chk("t2_sp_valid", data_valid, 1);
        chk("t2_sp_isr2", in_service_register, 0);
        tick();

        // AEOI with rotation on level 5
        auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
        interrupt = 8'h20;
        tick();
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        interrupt  = 8'h00;
        chk("t3_isr_set", in_service_register, 8'h20);
        sb_q.push_back({vector_base, 3'd5});
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        chk("t3_isr_aeoi", in_service_register, 0);
        chk("t3_rot", priority_rotate, 5);
        tick();
        auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
        ack(3'd0);
        ack(3'd6);
        chk("t3_isr41", in_service_register, 8'h41);
        chk("t3_hl6", highest_level_in_service, 8'h40);
        eoi(1'b0, 1'b0, 3'd0);
        chk("t3_ns_eoi", in_service_register, 8'h01);
        chk("t3_ns_norot", priority_rotate, 5);
        eoi(1'b0, 1'b0, 3'd0);
        chk("t3_ns_eoi2", in_service_register, 0);

        // Non-specific EOI with rotation from rotate=7
        set_prio(3'd7);
        chk("t4_setprio", priority_rotate, 7);
        ack(3'd0);
        ack(3'd5);
        chk("t4_isr21", in_service_register, 8'h21);
        chk("t4_hl", highest_level_in_service, 8'h01);
        eoi(1'b0, 1'b1, 3'd3);
        chk("t4_isr", in_service_register, 8'h20);
        chk("t4_rot", priority_rotate, 0);
        eoi(1'b1, 1'b0, 3'd5);
        chk("t4_clr5", in_service_register, 0);
        eoi(1'b0, 1'b1, 3'd3);
        chk("t4_empty_isr", in_service_register, 0);
        chk("t4_empty_rot", priority_rotate, 0);

        // Specific EOI together with set-priority
        ack(3'd0);
        ack(3'd5);
        set_priority_strobe = 1'b1;
        eoi(1'b1, 1'b0, 3'd5);
        set_priority_strobe = 1'b0;
        chk("t5_isr", in_service_register, 8'h01);
        chk("t5_rot", priority_rotate, 5);
        // EOI and first INTA on the same already-set level: set wins
        interrupt = 8'h01;
        tick();
        inta_pulse = 1'b1;
        eoi_strobe = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0;
        tick();
        inta_pulse = 1'b0; eoi_strobe = 1'b0; eoi_specific = 1'b0;
        interrupt  = 8'h00;
        chk("t5_set_wins", in_service_register, 8'h01);
        chk("t5_clr", clear_request, 8'h01);
        sb_q.push_back({vector_base, 3'd0});
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        tick();
        eoi(1'b1, 1'b0, 3'd0);

        // init_strobe in WAIT_ACK2
        vector_base = 5'b10101;
        interrupt = 8'h02;
        tick();
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        interrupt  = 8'h00;
        chk("t6_isr_pre", in_service_register, 8'h02);
        init_strobe = 1'b1;
        tick();
        init_strobe = 1'b0;
        chk("t6_init_isr", in_service_register, 0);
        chk("t6_init_rot", priority_rotate, 7);
        chk("t6_init_int", int_out, 0);
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        chk("t6_init_novalid", data_valid, 0);
        tick();

        // reset_n in WAIT_ACK2
        set_prio(3'd3);
        interrupt = 8'h08;
        tick();
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        interrupt  = 8'h00;
        chk("t6_rst_pre", in_service_register, 8'h08);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_rst_isr", in_service_register, 0);
        chk("t6_rst_rot", priority_rotate, 7);
        chk("t6_rst_int", int_out, 0);
        inta_pulse = 1'b1;
        tick();
        inta_pulse = 1'b0;
        chk("t6_rst_novalid", data_valid, 0);
        tick();
        tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
